// File: rtl/serial_tcs_sub_if.sv
// Handshake and result bundle for the bit-serial two's-complement subtractor.
// The master issues start with its operands; the slave returns busy/done and results.
interface serial_tcs_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             overflow;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow, overflow
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow, overflow
    );
endinterface

// File: rtl/serial_tcs_sub.sv
// Bit-serial two's-complement subtractor: diff = a + ~b + 1, one bit per clock,
// LSB first, through a single full-adder cell and a carry flop.
module serial_tcs_sub #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    serial_tcs_sub_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] sh_d;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             a_msb;
    logic             b_msb;
    logic             borrow_q;
    logic             ovf_q;
    logic             sum_bit;
    logic             carry_nxt;
    logic             last_bit;

    // Full-adder cell on the current LSBs plus the last-bit detector.
    always_comb begin
        sum_bit   = sh_a[0] ^ sh_b[0] ^ carry;
        carry_nxt = (sh_a[0] & sh_b[0]) | (sh_a[0] & carry) | (sh_b[0] & carry);
        last_bit  = (cnt == LAST_CNT);
    end

    // State register; an asynchronous reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: flops use non-blocking (<=) so every register samples pre-edge values.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: accept start only in IDLE, shift WIDTH bits, pulse DONE once.
    always_comb begin
        // NOTE: default assigned first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = SHIFT;
            SHIFT:   if (last_bit)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: load on accepted start, shift one bit per SHIFT cycle,
    // latch borrow/overflow on the edge that writes the last bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_a     <= '0;
            sh_b     <= '0;
            sh_d     <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sh_a  <= bus.a;
                        sh_b  <= ~bus.b;
                        carry <= 1'b1;
                        cnt   <= '0;
                        a_msb <= bus.a[WIDTH-1];
                        b_msb <= bus.b[WIDTH-1];
                    end
                end
                SHIFT: begin
                    sh_a  <= sh_a >> 1;
                    sh_b  <= sh_b >> 1;
                    sh_d  <= {sum_bit, sh_d[WIDTH-1:1]};
                    carry <= carry_nxt;
                    cnt   <= cnt + 1'b1;
                    if (last_bit) begin
                        // sum_bit on this edge becomes diff's MSB.
                        borrow_q <= ~carry_nxt;
                        ovf_q    <= (a_msb != b_msb) && (sum_bit != a_msb);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = (state == SHIFT);
    assign bus.done     = (state == DONE);
    assign bus.diff     = sh_d;
    assign bus.borrow   = borrow_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_serial_tcs_sub.sv
// Self-checking bench for serial_tcs_sub: an 8-bit and a 2-bit instance share the
// clock and reset. Drivers push expected results; monitors pop and compare on done.
module tb_serial_tcs_sub;
    localparam int W8 = 8;
    localparam int W2 = 2;

    typedef struct packed {
        logic [7:0] diff;
        logic       bor;
        logic       ovf;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp8[$];
    exp_t exp2[$];

    serial_tcs_sub_if #(.WIDTH(W8)) if8 ();
    serial_tcs_sub_if #(.WIDTH(W2)) if2 ();

    serial_tcs_sub #(.WIDTH(W8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
    serial_tcs_sub #(.WIDTH(W2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain modular and signed integer arithmetic.
    function automatic exp_t ref_sub(input int a, input int b, input int w);
        exp_t r;
        int   m;
        int   sa;
        int   sb;
        int   d;
        m  = 1 << w;
        sa = (a >= m / 2) ? a - m : a;
        sb = (b >= m / 2) ? b - m : b;
        d  = sa - sb;
        r.diff = 8'((((a - b) % m) + m) % m);
        r.bor  = (a < b);
        r.ovf  = (d < -(m / 2)) || (d > (m / 2) - 1);
        return r;
    endfunction

    // Monitor for the 8-bit instance.
    always @(negedge clk) begin
        if (!rst && if8.done) begin
            if (exp8.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL done8_unexpected: got done with no request pending, expected none");
            end else begin
                exp_t e;
                e = exp8.pop_front();
                check("diff8",     32'(if8.diff),     32'(e.diff));
                check("borrow8",   32'(if8.borrow),   32'(e.bor));
                check("overflow8", 32'(if8.overflow), 32'(e.ovf));
                check("busy8_at_done", 32'(if8.busy), 32'd0);
            end
        end
    end

    // Monitor for the 2-bit instance.
    always @(negedge clk) begin
        if (!rst && if2.done) begin
            if (exp2.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL done2_unexpected: got done with no request pending, expected none");
            end else begin
                exp_t e;
                e = exp2.pop_front();
                check("diff2",     32'(if2.diff),     32'(e.diff));
                check("borrow2",   32'(if2.borrow),   32'(e.bor));
                check("overflow2", 32'(if2.overflow), 32'(e.ovf));
            end
        end
    end

    // One 8-bit operation with timing checks; operands are scrambled after acceptance.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input exp_t e, input string tag);
        int busy_cnt;
        int done_cnt;
        int done_at;
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = -1;
        @(negedge clk);
        if8.a     = a;
        if8.b     = b;
        if8.start = 1'b1;
        exp8.push_back(e);
        // Sample j is taken after edge E(j), E0 being the accepting edge.
        for (int j = 0; j <= W8 + 1; j++) begin
            @(negedge clk);
            if (j == 0) begin
                if8.start = 1'b0;
                if8.a     = 8'($urandom);
                if8.b     = 8'($urandom);
            end
            if (if8.busy) busy_cnt++;
            if (if8.done) begin
                done_cnt++;
                if (done_at < 0) done_at = j;
            end
        end
        check({"busy_cycles_", tag}, 32'(busy_cnt), 32'(W8));
        check({"done_edge_", tag},   32'(done_at),  32'(W8));
        check({"done_pulses_", tag}, 32'(done_cnt), 32'd1);
    endtask

    task automatic op2(input logic [1:0] a, input logic [1:0] b);
        @(negedge clk);
        if2.a     = a;
        if2.b     = b;
        if2.start = 1'b1;
        exp2.push_back(ref_sub(int'(a), int'(b), W2));
        for (int j = 0; j <= W2 + 1; j++) begin
            @(negedge clk);
            if (j == 0) if2.start = 1'b0;
        end
    endtask

    task automatic check_zero8(input string tag);
        check({"rst_diff_", tag},     32'(if8.diff),     32'd0);
        check({"rst_borrow_", tag},   32'(if8.borrow),   32'd0);
        check({"rst_overflow_", tag}, 32'(if8.overflow), 32'd0);
        check({"rst_busy_", tag},     32'(if8.busy),     32'd0);
        check({"rst_done_", tag},     32'(if8.done),     32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int done_seen;
        rst       = 1'b1;
        if8.start = 1'b0;
        if8.a     = '0;
        if8.b     = '0;
        if2.start = 1'b0;
        if2.a     = '0;
        if2.b     = '0;
        repeat (3) @(negedge clk);
        check_zero8("power_on");
        rst = 1'b0;

        // Directed vectors with fixed expected results.
        op8(8'h05, 8'h03, '{diff: 8'h02, bor: 1'b0, ovf: 1'b0}, "5m3");
        op8(8'h03, 8'h05, '{diff: 8'hFE, bor: 1'b1, ovf: 1'b0}, "3m5");

        // Reset while idle clears held results immediately.
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_zero8("idle");
        @(negedge clk);
        rst = 1'b0;

        op8(8'h00, 8'h00, '{diff: 8'h00, bor: 1'b0, ovf: 1'b0}, "0m0");
        op8(8'h80, 8'h01, '{diff: 8'h7F, bor: 1'b0, ovf: 1'b1}, "80m01");
        op8(8'h7F, 8'hFF, '{diff: 8'h80, bor: 1'b1, ovf: 1'b1}, "7Fm FF");

        // Reset mid-SHIFT (third shift cycle): aborts with no done.
        @(negedge clk);
        if8.a     = 8'hAB;
        if8.b     = 8'h12;
        if8.start = 1'b1;
        @(negedge clk);
        if8.start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check_zero8("mid_shift");
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        repeat (W8 + 4) begin
            @(negedge clk);
            if (if8.done) done_seen++;
        end
        check("no_done_after_abort", 32'(done_seen), 32'd0);

        // A fresh operation after the abort completes normally.
        op8(8'h12, 8'hAB, '{diff: 8'h67, bor: 1'b1, ovf: 1'b0}, "after_abort");

        // Randomized operations against the reference model.
        for (int k = 0; k < 12; k++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = 8'($urandom);
            rb = 8'($urandom);
            op8(ra, rb, ref_sub(int'(ra), int'(rb), W8), $sformatf("rnd%0d", k));
        end

        // Start held high with operands changing every cycle: one acceptance
        // every W8+2 edges, each using the operands present at that edge.
        for (int k = 0; k < 4 * (W8 + 2); k++) begin
            @(negedge clk);
            if8.start = 1'b1;
            if8.a     = 8'($urandom);
            if8.b     = 8'($urandom);
            if (k % (W8 + 2) == 0)
                exp8.push_back(ref_sub(int'(if8.a), int'(if8.b), W8));
        end
        @(negedge clk);
        if8.start = 1'b0;
        repeat (W8 + 3) @(negedge clk);

        // Exhaustive 2-bit sweep.
        for (int x = 0; x < 4; x++)
            for (int y = 0; y < 4; y++)
                op2(2'(x), 2'(y));

        repeat (4) @(negedge clk);
        check("pending8_drained", 32'(exp8.size()), 32'd0);
        check("pending2_drained", 32'(exp2.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
